// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, default bus widths
// and the registered response bundle.
package apb_pkg;

  localparam int APB_ADDR_W    = 32;
  localparam int APB_DATA_W    = 32;
  // Response bundle is sized for the widest supported bus; narrower instances
  // use the low bits. DATA_W must not exceed this.
  localparam int APB_RSP_MAX_W = 64;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic [APB_RSP_MAX_W-1:0] rdata;
    logic                     err;
    logic                     timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command into a single APB transfer,
// honours pready wait states, reports pslverr and aborts stalled accesses.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      wait_nxt;
  logic             hit_limit;
  logic             accept;
  apb_rsp_t         rsp_q;

  assign cmd_ready = (state == APB_IDLE) && !preset;
  assign accept    = cmd_valid && cmd_ready;

  // The current low-pready cycle is the one that would bring the count to the
  // limit; pready high in that same cycle still completes the transfer.
  assign wait_nxt  = 32'(wait_cnt) + 32'd1;
  assign hit_limit = (TIMEOUT_CYCLES != 0) && (wait_nxt >= 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state)
      APB_IDLE: begin
        if (cmd_valid) state_nxt = APB_SETUP;
      end
      APB_SETUP: begin
        psel      = 1'b1;
        state_nxt = APB_ACCESS;
      end
      APB_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || hit_limit) state_nxt = APB_IDLE;
      end
      default: state_nxt = APB_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= APB_IDLE;
      wait_cnt  <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= 1'b0;

      if (accept) begin
        pwrite   <= cmd_write;
        paddr    <= cmd_addr;
        pwdata   <= cmd_write ? cmd_wdata : '0;
        wait_cnt <= '0;
      end

      if (state == APB_ACCESS) begin
        if (pready) begin
          rsp_valid     <= 1'b1;
          rsp_q.rdata   <= pwrite ? '0 : APB_RSP_MAX_W'(prdata);
          rsp_q.err     <= pslverr;
          rsp_q.timeout <= 1'b0;
        end else begin
          if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
          if (hit_limit) begin
            rsp_valid     <= 1'b1;
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
          end
        end
      end
    end
  end

  assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule
